// File: rtl/alu_operand_stage.sv
// Purpose : operand fetch for the ALU. A 32x32 register file is read with
//           writeback bypass, and the result is held in a single output register.
// Latency : 1 cycle from accept to out_valid. Backpressure: in_ready = !out_valid || out_ready,
//           so a full drain and a new accept can happen on the same edge.
// Ports   : clk/rst (async, active-high); in_* = upstream op (valid/ready, rs1/rs2/rd,
//           alu_op, use_imm/imm); wb_* = result writeback; out_* = operand bundle
//           (valid/ready); issue_count = number of completed output handshakes.
module alu_operand_stage #(
  parameter int CNT_W = 16,
  parameter int IMM_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  input  logic [3:0]       in_alu_op,
  input  logic             in_use_imm,
  input  logic [IMM_W-1:0] in_imm,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_op1,
  output logic [31:0]      out_op2,
  output logic [3:0]       out_alu_op,
  output logic [4:0]       out_rd,
  output logic [CNT_W-1:0] issue_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0] regs [32];
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic        use_imm_q;

  logic        accept;
  logic        hold;
  logic        wb_en;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] imm_ext;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign hold     = out_valid && !out_ready;
  // Writes to x0 are dropped here, so everything below may rely on wb_en implying wb_rd != 0.
  assign wb_en    = wb_valid && (wb_rd != 5'd0);
  assign imm_ext  = {{(32-IMM_W){in_imm[IMM_W-1]}}, in_imm};

  // Source read with same-cycle writeback bypass; x0 is hard-wired to zero.
  always_comb begin
    src1 = 32'd0;
    src2 = 32'd0;
    if (in_rs1 != 5'd0) src1 = (wb_en && wb_rd == in_rs1) ? wb_data : regs[in_rs1];
    if (in_rs2 != 5'd0) src2 = (wb_en && wb_rd == in_rs2) ? wb_data : regs[in_rs2];
  end

  // Register file. Entry 0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (wb_en) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Output bundle register and issue counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_op1     <= 32'd0;
      out_op2     <= 32'd0;
      out_alu_op  <= 4'd0;
      out_rd      <= 5'd0;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      use_imm_q   <= 1'b0;
      issue_count <= '0;
    end else begin
      if (out_valid && out_ready) issue_count <= issue_count + CNT_ONE;

      if (accept) begin
        out_valid  <= 1'b1;
        out_op1    <= src1;
        out_op2    <= in_use_imm ? imm_ext : src2;
        out_alu_op <= in_alu_op;
        out_rd     <= in_rd;
        rs1_q      <= in_rs1;
        rs2_q      <= in_rs2;
        use_imm_q  <= in_use_imm;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end else if (hold) begin
        // A stalled bundle snoops writebacks so it never issues with stale operands.
        // The immediate operand is never replaced.
        if (wb_en && wb_rd == rs1_q) out_op1 <= wb_data;
        if (wb_en && wb_rd == rs2_q && !use_imm_q) out_op2 <= wb_data;
      end
    end
  end

endmodule
